// File: rtl/slowtick_monitor.sv
// Slow-tick health monitor: measures fastclock cycles between tick strobes and
// flags fast/slow/missing ticks. Optional miss counter behind SLOWTICK_MISSCNT_EN.
module slowtick_monitor #(
    parameter int CNT_W   = 18,
    parameter int NOMINAL = 156251,
    parameter int TOL     = 16,
    parameter int LOCK_N  = 4
) (
    input  logic             fastclock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             clr_flags,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             timeout,
    output logic             locked
`ifdef SLOWTICK_MISSCNT_EN
    ,
    output logic [7:0]       miss_count
`endif
);

    localparam logic [CNT_W-1:0] LO      = CNT_W'(NOMINAL - TOL);
    localparam logic [CNT_W-1:0] HI      = CNT_W'(NOMINAL + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);

    typedef enum logic {WAIT_FIRST, MEASURE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       good_q, good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             fast_q, fast_d;
    logic             slow_q, slow_d;
    logic             to_q, to_d;
    logic             lock_q, lock_d;
    logic             fast_evt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        period_d = period_q;
        pv_d     = 1'b0;
        fast_d   = fast_q & ~clr_flags;
        slow_d   = slow_q & ~clr_flags;
        to_d     = 1'b0;
        lock_d   = lock_q;
        fast_evt = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                cnt_d = '0;
                if (tick) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (tick) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    cnt_d    = CNT_W'(1);
                    if (cnt_q < LO) begin
                        fast_d   = 1'b1;
                        fast_evt = 1'b1;
                        good_d   = '0;
                        lock_d   = 1'b0;
                    end else if (cnt_q > HI) begin
                        slow_d = 1'b1;
                        good_d = '0;
                        lock_d = 1'b0;
                    end else if (good_q >= LOCK_V - 4'd1) begin
                        good_d = LOCK_V;
                        lock_d = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    // cnt passes HI exactly once per interval, so the pulse cannot repeat
                    if (cnt_q == HI) begin
                        to_d   = 1'b1;
                        slow_d = 1'b1;
                        good_d = '0;
                        lock_d = 1'b0;
                    end
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge fastclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_FIRST;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            fast_q   <= 1'b0;
            slow_q   <= 1'b0;
            to_q     <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            fast_q   <= fast_d;
            slow_q   <= slow_d;
            to_q     <= to_d;
            lock_q   <= lock_d;
        end
    end

`ifdef SLOWTICK_MISSCNT_EN
    logic [7:0] miss_q, miss_d;

    always_comb begin
        miss_d = miss_q;
        if (to_d || fast_evt) begin
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        end else if (clr_flags) begin
            miss_d = '0;
        end
    end

    always_ff @(posedge fastclock or negedge reset_n) begin
        if (!reset_n) miss_q <= '0;
        else          miss_q <= miss_d;
    end

    assign miss_count = miss_q;
`else
    logic unused_fast_evt;
    assign unused_fast_evt = fast_evt;
`endif

    assign period       = period_q;
    assign period_valid = pv_q;
    assign too_fast     = fast_q;
    assign too_slow     = slow_q;
    assign timeout      = to_q;
    assign locked       = lock_q;

endmodule

// File: tb/tb_slowtick_monitor.sv
// Directed, table-driven bench for slowtick_monitor at NOMINAL=20, TOL=2, LOCK_N=3, CNT_W=8.
module tb_slowtick_monitor;

    logic       fastclock = 1'b0;
    logic       reset_n   = 1'b0;
    logic       tick      = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] period;
    logic       period_valid, too_fast, too_slow, timeout, locked;
`ifdef SLOWTICK_MISSCNT_EN
    logic [7:0] miss_count;
    int         miss_m = 0;
`endif

    int checks = 0;
    int errors = 0;

    slowtick_monitor #(.CNT_W(8), .NOMINAL(20), .TOL(2), .LOCK_N(3)) dut (
        .fastclock   (fastclock),
        .reset_n     (reset_n),
        .tick        (tick),
        .clr_flags   (clr_flags),
        .period      (period),
        .period_valid(period_valid),
        .too_fast    (too_fast),
        .too_slow    (too_slow),
        .timeout     (timeout),
        .locked      (locked)
`ifdef SLOWTICK_MISSCNT_EN
        ,
        .miss_count  (miss_count)
`endif
    );

    always #5 fastclock = ~fastclock;

    // gap: edges from the previous tick edge to this one; clr: 0 none, 1 first idle cycle, 2 on tick
    typedef struct {
        int gap;
        int clr;
        int exp_pv;
        int exp_p;
        int exp_fast;
        int exp_slow;
        int exp_lock;
        int to_idx;
    } vec_t;

    vec_t vt[25];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic mstep(input bit inc, input bit clr);
`ifdef SLOWTICK_MISSCNT_EN
        if (inc) begin
            if (miss_m < 255) miss_m++;
        end else if (clr) begin
            miss_m = 0;
        end
`endif
    endtask

    task automatic cyc(input logic t, input logic c);
        tick      = t;
        clr_flags = c;
        @(posedge fastclock);
        @(negedge fastclock);
        tick      = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic send(input vec_t v, input int id);
        int to_seen = 0;
        int to_at   = 0;
        int pv_seen = 0;
        for (int k = 1; k < v.gap; k++) begin
            cyc(1'b0, (v.clr == 1) && (k == 1));
            mstep(k == v.to_idx, (v.clr == 1) && (k == 1));
            if (timeout) begin
                to_seen++;
                to_at = k;
            end
            if (period_valid) pv_seen++;
        end
        chk($sformatf("v%0d_timeout_pulses", id), to_seen, (v.to_idx != 0) ? 1 : 0);
        if (v.to_idx != 0) chk($sformatf("v%0d_timeout_at", id), to_at, v.to_idx);
        chk($sformatf("v%0d_idle_pv", id), pv_seen, 0);
        cyc(1'b1, v.clr == 2);
        mstep(v.exp_pv != 0 && v.exp_p < 18, v.clr == 2);
        chk($sformatf("v%0d_pv", id), int'(period_valid), v.exp_pv);
        chk($sformatf("v%0d_period", id), int'(period), v.exp_p);
        chk($sformatf("v%0d_too_fast", id), int'(too_fast), v.exp_fast);
        chk($sformatf("v%0d_too_slow", id), int'(too_slow), v.exp_slow);
        chk($sformatf("v%0d_locked", id), int'(locked), v.exp_lock);
        chk($sformatf("v%0d_tick_timeout", id), int'(timeout), 0);
`ifdef SLOWTICK_MISSCNT_EN
        chk($sformatf("v%0d_miss_count", id), int'(miss_count), miss_m);
`endif
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_period"}, int'(period), 0);
        chk({nm, "_pv"}, int'(period_valid), 0);
        chk({nm, "_too_fast"}, int'(too_fast), 0);
        chk({nm, "_too_slow"}, int'(too_slow), 0);
        chk({nm, "_timeout"}, int'(timeout), 0);
        chk({nm, "_locked"}, int'(locked), 0);
`ifdef SLOWTICK_MISSCNT_EN
        chk({nm, "_miss_count"}, int'(miss_count), 0);
`endif
    endtask

    initial begin
        vt[0]  = '{5,   0, 0, 0,   0, 0, 0, 0};
        vt[1]  = '{20,  0, 1, 20,  0, 0, 0, 0};
        vt[2]  = '{20,  0, 1, 20,  0, 0, 0, 0};
        vt[3]  = '{20,  0, 1, 20,  0, 0, 1, 0};
        vt[4]  = '{20,  0, 1, 20,  0, 0, 1, 0};
        vt[5]  = '{15,  0, 1, 15,  1, 0, 0, 0};
        vt[6]  = '{20,  0, 1, 20,  1, 0, 0, 0};
        vt[7]  = '{20,  0, 1, 20,  1, 0, 0, 0};
        vt[8]  = '{20,  0, 1, 20,  1, 0, 1, 0};
        vt[9]  = '{20,  1, 1, 20,  0, 0, 1, 0};
        vt[10] = '{18,  0, 1, 18,  0, 0, 1, 0};
        vt[11] = '{22,  0, 1, 22,  0, 0, 1, 0};
        vt[12] = '{17,  0, 1, 17,  1, 0, 0, 0};
        vt[13] = '{20,  1, 1, 20,  0, 0, 0, 0};
        vt[14] = '{20,  0, 1, 20,  0, 0, 0, 0};
        vt[15] = '{23,  0, 1, 23,  0, 1, 0, 22};
        vt[16] = '{22,  0, 1, 22,  0, 1, 0, 0};
        vt[17] = '{20,  0, 1, 20,  0, 1, 0, 0};
        vt[18] = '{20,  0, 1, 20,  0, 1, 1, 0};
        vt[19] = '{40,  1, 1, 40,  0, 1, 0, 22};
        vt[20] = '{300, 0, 1, 255, 0, 1, 0, 22};
        vt[21] = '{7,   0, 0, 0,   0, 0, 0, 0};
        vt[22] = '{20,  0, 1, 20,  0, 0, 0, 0};
        vt[23] = '{25,  2, 1, 25,  0, 1, 0, 22};
        vt[24] = '{15,  2, 1, 15,  1, 0, 0, 0};

        #12;
        chk_zero("reset");
        @(negedge fastclock);
        reset_n = 1'b1;

        for (int i = 0; i <= 20; i++) send(vt[i], i);

        // async reset in the middle of an interval
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_zero("midreset");
`ifdef SLOWTICK_MISSCNT_EN
        miss_m = 0;
`endif
        @(negedge fastclock);
        reset_n = 1'b1;

        for (int i = 21; i <= 24; i++) send(vt[i], i);

        // tick held high: period 1 every cycle
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0);
            mstep(1'b1, 1'b0);
            chk($sformatf("held%0d_pv", k), int'(period_valid), 1);
            chk($sformatf("held%0d_period", k), int'(period), 1);
            chk($sformatf("held%0d_too_fast", k), int'(too_fast), 1);
            chk($sformatf("held%0d_locked", k), int'(locked), 0);
`ifdef SLOWTICK_MISSCNT_EN
            chk($sformatf("held%0d_miss_count", k), int'(miss_count), miss_m);
`endif
        end
        cyc(1'b0, 1'b0);
        chk("after_held_pv", int'(period_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
